// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state codes, frame bit
// indices and helpers that turn the 100 kHz-unit clock rate into cycle counts.
package ps2_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_INHIBIT = 3'd1;
   localparam logic [2:0] ST_START   = 3'd2;
   localparam logic [2:0] ST_BITS    = 3'd3;
   localparam logic [2:0] ST_ACK     = 3'd4;
   localparam logic [2:0] ST_RECOVER = 3'd5;

   localparam logic [3:0] PARITY_IDX = 4'd8;
   localparam logic [3:0] STOP_IDX   = 4'd9;

   // One 100 kHz unit of clock rate is 10 cycles per 100 us and 100 cycles per ms.
   localparam int CYCLES_PER_100US_UNIT = 10;
   localparam int CYCLES_PER_MS_UNIT    = 100;

   function automatic int inhibit_cycles(input int sysclk_units);
      return sysclk_units * CYCLES_PER_100US_UNIT;
   endfunction

   function automatic int timeout_cycles(input int sysclk_units, input int ms);
      return sysclk_units * CYCLES_PER_MS_UNIT * ms;
   endfunction

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   function automatic logic frame_bit(input logic [7:0] data, input logic parity,
                                      input logic [3:0] idx);
      logic value;
      value = 1'b1;
      if (idx < PARITY_IDX) begin
         value = data[idx[2:0]];
      end else if (idx == PARITY_IDX) begin
         value = parity;
      end
      return value;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus falling-edge detector for one PS/2 line.
// With PS2_HOST_TX_FILTER_EN defined the synchronised level is debounced (8 equal samples).
module ps2_line_sync
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pin_in,
   output logic level_out,
   output logic fall_out
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic level;

   // Lines idle high, so the chain resets to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= pin_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef PS2_HOST_TX_FILTER_EN
   logic       filt_q;
   logic       filt_d;
   logic [2:0] run_q;
   logic [2:0] run_d;

   always_comb begin
      filt_d = filt_q;
      run_d  = 3'd0;
      if (sync2_q != filt_q) begin
         run_d = run_q + 3'd1;
         if (run_q == 3'd7) begin
            filt_d = sync2_q;
            run_d  = 3'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= 1'b1;
         run_q  <= 3'd0;
      end else begin
         filt_q <= filt_d;
         run_q  <= run_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level;
      end
   end

   assign level_out = level;
   assign fall_out  = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with inhibit, framing, ack check and watchdog.
// Optional clock debounce is enabled by defining PS2_HOST_TX_FILTER_EN.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int sysclk_frequency = 1000,
   parameter int timeout_ms       = 2
)
(
   input  logic       clk,
   input  logic       reset_in,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_out,
   output logic       ps2_dat_out,
   input  logic [7:0] tx_data,
   input  logic       tx_req,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int INHIBIT_CYCLES = inhibit_cycles(sysclk_frequency);
   localparam int TIMEOUT_CYCLES = timeout_cycles(sysclk_frequency, timeout_ms);
   localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [TW-1:0] INHIBIT_LAST  = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] INHIBIT_DATLO = TW'(INHIBIT_CYCLES - 2);
   localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);

   logic          clk_level;
   logic          clk_fall;
   logic          dat_level;
   logic          dat_fall_unused;

   logic [2:0]    state_q,   state_d;
   logic [TW-1:0] timer_q,   timer_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    data_q,    data_d;
   logic          parity_q,  parity_d;
   logic          clk_out_q, clk_out_d;
   logic          dat_out_q, dat_out_d;
   logic          busy_q,    busy_d;
   logic          done_q,    done_d;
   logic          error_q,   error_d;
   logic          armed_q,   armed_d;

   ps2_line_sync u_clk_sync (
      .clk       (clk),
      .rst       (reset_in),
      .pin_in    (ps2_clk_in),
      .level_out (clk_level),
      .fall_out  (clk_fall)
   );

   ps2_line_sync u_dat_sync (
      .clk       (clk),
      .rst       (reset_in),
      .pin_in    (ps2_dat_in),
      .level_out (dat_level),
      .fall_out  (dat_fall_unused)
   );

   // timer_q counts the inhibit period in INHIBIT and acts as the watchdog afterwards.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      parity_d  = parity_q;
      clk_out_d = clk_out_q;
      dat_out_d = dat_out_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      armed_d   = 1'b1;

      case (state_q)
         ST_IDLE: begin
            clk_out_d = 1'b1;
            dat_out_d = 1'b1;
            timer_d   = '0;
            bit_idx_d = 4'd0;
            if (tx_req && armed_q) begin
               data_d    = tx_data;
               parity_d  = odd_parity(tx_data);
               busy_d    = 1'b1;
               clk_out_d = 1'b0;
               state_d   = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == INHIBIT_DATLO) begin
               dat_out_d = 1'b0;
            end
            if (timer_q == INHIBIT_LAST) begin
               clk_out_d = 1'b1;
               dat_out_d = 1'b0;
               timer_d   = '0;
               state_d   = ST_START;
            end
         end

         ST_START, ST_BITS, ST_ACK, ST_RECOVER: begin
            timer_d = clk_fall ? '0 : timer_q + 1'b1;

            if (state_q == ST_START) begin
               if (clk_fall) begin
                  bit_idx_d = 4'd0;
                  dat_out_d = data_q[0];
                  state_d   = ST_BITS;
               end
            end else if (state_q == ST_BITS) begin
               if (clk_fall) begin
                  if (bit_idx_q == STOP_IDX) begin
                     state_d = ST_ACK;
                  end else begin
                     bit_idx_d = bit_idx_q + 4'd1;
                     dat_out_d = frame_bit(data_q, parity_q, bit_idx_q + 4'd1);
                  end
               end
            end else if (state_q == ST_ACK) begin
               if (!dat_level) begin
                  state_d = ST_RECOVER;
               end else begin
                  clk_out_d = 1'b1;
                  dat_out_d = 1'b1;
                  busy_d    = 1'b0;
                  error_d   = 1'b1;
                  state_d   = ST_IDLE;
               end
            end else begin
               if (clk_level && dat_level) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end

            // A stalled device releases the bus; completion or nack in the same cycle wins.
            if (!done_d && !error_d && !clk_fall && timer_q == TIMEOUT_LAST) begin
               clk_out_d = 1'b1;
               dat_out_d = 1'b1;
               busy_d    = 1'b0;
               error_d   = 1'b1;
               state_d   = ST_IDLE;
            end
         end

         default: begin
            clk_out_d = 1'b1;
            dat_out_d = 1'b1;
            busy_d    = 1'b0;
            timer_d   = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // armed_q masks a request that arrives on the first edge after reset release.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         bit_idx_q <= 4'd0;
         data_q    <= 8'd0;
         parity_q  <= 1'b0;
         clk_out_q <= 1'b1;
         dat_out_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         parity_q  <= parity_d;
         clk_out_q <= clk_out_d;
         dat_out_q <= dat_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         armed_q   <= armed_d;
      end
   end

   assign ps2_clk_out = clk_out_q;
   assign ps2_dat_out = dat_out_q;
   assign tx_busy     = busy_q;
   assign tx_done     = done_q;
   assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain device model clocking at 10 kHz.
// Define PS2_HOST_TX_FILTER_EN to add the clock-glitch scenario and filtered latencies.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int HALF    = 50;
   localparam int INHIBIT = 100;
   localparam int TIMEOUT = 2000;
`ifdef PS2_HOST_TX_FILTER_EN
   localparam int EDGE_LAT = 11;
`else
   localparam int EDGE_LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       reset_in = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       tx_req = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       ps2_clk_in, ps2_dat_in, ps2_clk_out, ps2_dat_out;
   logic       tx_busy, tx_done, tx_error;

   int   vectors = 0;
   int   miscompares = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   both_cnt = 0;
   logic busy_at_done = 1'b1;

   assign ps2_clk_in = dev_clk & ps2_clk_out;
   assign ps2_dat_in = dev_dat & ps2_dat_out;

   always #5 clk = ~clk;

   ps2_host_tx #(.sysclk_frequency(10), .timeout_ms(2)) dut (
      .clk         (clk),
      .reset_in    (reset_in),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_dat_in  (ps2_dat_in),
      .ps2_clk_out (ps2_clk_out),
      .ps2_dat_out (ps2_dat_out),
      .tx_data     (tx_data),
      .tx_req      (tx_req),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_error    (tx_error)
   );

   always @(negedge clk) begin
      if (tx_done) begin
         done_cnt++;
         busy_at_done = tx_busy;
      end
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) both_cnt++;
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      tx_req  = 1'b1;
      @(negedge clk);
      tx_req  = 1'b0;
   endtask

   task automatic measure_inhibit(output int low_cycles, output logic dat_prev,
                                  output logic dat_last);
      low_cycles = 0;
      dat_prev   = 1'bx;
      dat_last   = 1'bx;
      while (ps2_clk_out === 1'b0 && low_cycles < 1000) begin
         low_cycles++;
         dat_prev = dat_last;
         dat_last = ps2_dat_out;
         @(negedge clk);
      end
   endtask

   task automatic dev_pulse(output logic sampled);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      sampled = ps2_dat_out;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic dev_bits(input int n, output logic [9:0] bits);
      logic b;
      bits = 10'h000;
      for (int i = 0; i < n; i++) begin
         dev_pulse(b);
         bits[i] = b;
      end
   endtask

   task automatic dev_ack(input logic ack_low);
      dev_dat = ack_low ? 1'b0 : 1'b1;
      repeat (25) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (10) @(negedge clk);
      dev_dat = 1'b1;
      repeat (40) @(negedge clk);
   endtask

   task automatic wait_not_busy(output logic timed_out);
      int n;
      n = 0;
      while (tx_busy === 1'b1 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      timed_out = (tx_busy !== 1'b0);
   endtask

   initial begin
      int         low, d0, e0, n;
      logic       dp, dl, tmo;
      logic [9:0] bits;

      // Reset state and a request coincident with reset release.
      repeat (3) @(negedge clk);
      check_output("reset_state", {ps2_clk_out, ps2_dat_out, tx_busy, tx_done, tx_error}, 5'b11000);
      tx_data  = 8'hF4;
      tx_req   = 1'b1;
      reset_in = 1'b0;
      @(negedge clk);
      tx_req = 1'b0;
      repeat (3) @(negedge clk);
      check_output("req_at_reset_release", {tx_busy, ps2_clk_out}, 2'b01);

      // 0xF4 acknowledged transfer.
      d0 = done_cnt; e0 = err_cnt;
      apply_stimulus(8'hF4);
      check_output("accept_busy", tx_busy, 1'b1);
      measure_inhibit(low, dp, dl);
      check_output("inhibit_len", low, INHIBIT);
      check_output("inhibit_dat_before_last", dp, 1'b1);
      check_output("inhibit_dat_last", dl, 1'b0);
      check_output("start_bit", {ps2_clk_out, ps2_dat_out}, 2'b10);
      repeat (20) @(negedge clk);
      dev_bits(10, bits);
      check_output("f4_bits", bits, 10'h2F4);
      dev_ack(1'b1);
      wait_not_busy(tmo);
      check_output("f4_complete", tmo, 1'b0);
      check_output("f4_done_count", done_cnt - d0, 1);
      check_output("f4_error_count", err_cnt - e0, 0);
      check_output("f4_busy_at_done", busy_at_done, 1'b0);
      check_output("f4_released", {ps2_clk_out, ps2_dat_out}, 2'b11);

      // 0xED with the device leaving data high at ack time.
      d0 = done_cnt; e0 = err_cnt;
      apply_stimulus(8'hED);
      measure_inhibit(low, dp, dl);
      repeat (20) @(negedge clk);
      dev_bits(10, bits);
      check_output("ed_bits", bits, 10'h3ED);
      dev_ack(1'b0);
      wait_not_busy(tmo);
      check_output("ed_complete", tmo, 1'b0);
      check_output("ed_error_count", err_cnt - e0, 1);
      check_output("ed_done_count", done_cnt - d0, 0);
      check_output("ed_released", {ps2_clk_out, ps2_dat_out}, 2'b11);

      // Device stops clocking after bit 3 is driven.
      d0 = done_cnt; e0 = err_cnt;
      apply_stimulus(8'hA5);
      measure_inhibit(low, dp, dl);
      repeat (20) @(negedge clk);
      dev_bits(3, bits);
      dev_clk = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == HALF) dev_clk = 1'b1;
      end while (tx_error !== 1'b1 && n < 3000);
      check_output("timeout_latency", n, TIMEOUT + EDGE_LAT);
      check_output("timeout_released", {ps2_clk_out, ps2_dat_out, tx_busy}, 3'b110);
      repeat (5) @(negedge clk);
      check_output("timeout_pulses", {err_cnt - e0, done_cnt - d0}, {32'd1, 32'd0});

      // 0x00 with a stray 0xFF request while busy.
      d0 = done_cnt; e0 = err_cnt;
      apply_stimulus(8'h00);
      measure_inhibit(low, dp, dl);
      tx_data = 8'hFF;
      tx_req  = 1'b1;
      @(negedge clk);
      tx_req  = 1'b0;
      repeat (19) @(negedge clk);
      dev_bits(10, bits);
      check_output("ignore_bits", bits, 10'h300);
      dev_ack(1'b1);
      wait_not_busy(tmo);
      check_output("ignore_done_count", done_cnt - d0, 1);
      repeat (150) @(negedge clk);
      check_output("ignore_no_retrigger", {tx_busy, ps2_clk_out}, 2'b01);

      // Reset pulse during BITS, then a clean transfer.
      apply_stimulus(8'h00);
      measure_inhibit(low, dp, dl);
      repeat (20) @(negedge clk);
      dev_bits(3, bits);
      check_output("pre_reset_dat", ps2_dat_out, 1'b0);
      d0 = done_cnt; e0 = err_cnt;
      @(negedge clk);
      #1 reset_in = 1'b1;
      #1 check_output("async_reset_release", {ps2_clk_out, ps2_dat_out, tx_busy}, 3'b110);
      repeat (3) @(negedge clk);
      reset_in = 1'b0;
      repeat (5) @(negedge clk);
      check_output("reset_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);
      d0 = done_cnt;
      apply_stimulus(8'hF4);
      measure_inhibit(low, dp, dl);
      check_output("post_reset_inhibit_len", low, INHIBIT);
      repeat (20) @(negedge clk);
      dev_bits(10, bits);
      check_output("post_reset_bits", bits, 10'h2F4);
      dev_ack(1'b1);
      wait_not_busy(tmo);
      check_output("post_reset_done_count", done_cnt - d0, 1);

`ifdef PS2_HOST_TX_FILTER_EN
      // Short clock glitches must not advance the frame.
      d0 = done_cnt;
      apply_stimulus(8'hF4);
      measure_inhibit(low, dp, dl);
      repeat (20) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         dev_clk = 1'b0;
         repeat (3) @(negedge clk);
         dev_clk = 1'b1;
         repeat (20) @(negedge clk);
      end
      check_output("glitch_no_advance", {tx_busy, ps2_dat_out}, 2'b10);
      dev_bits(10, bits);
      check_output("glitch_bits", bits, 10'h2F4);
      dev_ack(1'b1);
      wait_not_busy(tmo);
      check_output("glitch_done_count", done_cnt - d0, 1);
`endif

      check_output("done_error_exclusive", both_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
- REQ-001 Parameter sysclk_frequency, default 1000, system clock in 100 kHz units (1000 = 100 MHz).
- REQ-002 Parameter timeout_ms, default 2, maximum wait for any device clock edge, in ms.
- REQ-003 clk  in  1  system clock, all logic rising-edge. One clock; reset is asynchronous and active-high.
- REQ-004 reset_in  in  1  asynchronous, active-high reset.
- REQ-005 ps2_clk_in  in  1  raw PS/2 clock pin level, asynchronous.
- REQ-006 ps2_dat_in  in  1  raw PS/2 data pin level, asynchronous.
- REQ-007 ps2_clk_out  out  1  open-drain control: 0 drives the pin low, 1 releases it.
- REQ-008 ps2_dat_out  out  1  open-drain control: 0 drives the pin low, 1 releases it.
- REQ-009 tx_data  in  8  command byte to send to the device.
- REQ-010 tx_req  in  1  single-cycle start strobe.
- REQ-011 tx_busy  out  1  high from acceptance until completion or error.
- REQ-012 tx_done  out  1  one-cycle pulse on acknowledged completion.
- REQ-013 tx_error  out  1  one-cycle pulse on missing ack or timeout.

Function
- REQ-014 ps2_clk_in and ps2_dat_in SHALL pass through 2-FF synchronisers; a device-clock falling edge is a synchronised 1->0 transition.
- REQ-015 FSM states SHALL be IDLE, INHIBIT, START, BITS, ACK, RECOVER.
- REQ-016 IDLE: tx_req latches tx_data and computes odd parity, goes to INHIBIT and sets tx_busy next cycle.
- REQ-017 A tx_req while tx_busy is high SHALL be ignored; tx_data is sampled only on the accepting cycle.
- REQ-018 INHIBIT: ps2_clk_out=0 for exactly sysclk_frequency*10 cycles (100 us); ps2_dat_out=0 asserted during the final cycle.
- REQ-019 START: release ps2_clk_out, hold ps2_dat_out=0 (start bit), wait for a falling edge.
- REQ-020 BITS: each falling edge updates ps2_dat_out within 1 cycle, in order d0..d7 (LSB first), parity, stop (1 = released); a 4-bit counter tracks bit index 0..9.
- REQ-021 After the stop bit is driven, the next falling edge goes to ACK, which samples synchronised data: 0 is ack, 1 pulses tx_error and goes to IDLE.
- REQ-022 RECOVER: wait until synchronised clk and data are both high, then pulse tx_done, clear tx_busy, and go to IDLE.
- REQ-023 Watchdog: in START, BITS, ACK and RECOVER, a counter reloads on every falling edge. If it reaches sysclk_frequency*100*timeout_ms cycles, the block SHALL release both lines, pulse tx_error, clear tx_busy and go to IDLE.
- REQ-024 tx_done and tx_error SHALL never assert in the same cycle.
- REQ-025 In IDLE both outputs SHALL be released (1).

Reset
- REQ-026 While reset_in is high: state=IDLE, ps2_clk_out=1, ps2_dat_out=1, tx_busy=0, tx_done=0, tx_error=0, counters=0, synchronisers=1.
- REQ-027 Reset asserted mid-transfer SHALL release both lines immediately (asynchronously), with no done or error pulse.
- REQ-028 tx_req coincident with reset_in deassertion SHALL be ignored.

Configuration
- REQ-029 Macro PS2_HOST_TX_FILTER_EN defined: the synchronised clock SHALL pass an 8-sample majority-free debounce, changing only after 8 consecutive equal samples, adding 8 cycles latency to edge detection.
- REQ-030 Macro not defined: edge detection SHALL use the 2-FF synchronised clock directly.

Structure
- REQ-031 Package ps2_pkg SHALL hold the FSM state enumeration, bit-index constants (PARITY_IDX=8, STOP_IDX=9) and the ms/us cycle-count helper constants.
- REQ-032 Sub-module ps2_line_sync SHALL implement the synchroniser, optional filter and falling-edge detect; it is instantiated once each for clock and data.

Verification (bench: sysclk_frequency=10, timeout_ms=2 -> inhibit 100 cycles, timeout 2000 cycles)
- REQ-033 tx_data=0xF4, tx_req, device model clocks at 10 kHz and acks -> ps2_clk_out low exactly 100 cycles; bits 0,0,1,0,1,1,1,1, parity 0, stop 1; single tx_done pulse; tx_busy falls with it.
- REQ-034 tx_data=0xED with device holding data high at ack -> parity bit 1 observed, tx_error pulse, no tx_done, lines released.
- REQ-035 Device stops clocking after bit 3 -> tx_error exactly 2000 cycles after the last falling edge; both outputs =1.
- REQ-036 Second tx_req=0xFF issued during transfer of 0x00 -> ignored; only 0x00 (parity 1) sent; one tx_done.
- REQ-037 reset_in pulsed during BITS -> ps2_clk_out and ps2_dat_out =1 in the same cycle, tx_busy=0, no pulses; a following tx_req=0xF4 completes normally.
- REQ-038 With PS2_HOST_TX_FILTER_EN, 3-cycle low glitches on ps2_clk_in -> no bit advance; clean edges -> identical bit sequence to REQ-033.
